button_press_detector: RTL

- Parametrised multi-channel successor to the single-button press latch.
- Per channel: synchronises a raw pushbutton, debounces it, and emits one-cycle press, release and long-press pulses.
- Per channel: keeps a sticky "pressed" flag that software/FSM logic clears explicitly. The old latch could never be cleared.
- Sits between the board pushbuttons and the app/menu FSMs; all outputs are synchronous to clk.

---
 rtl/button_press_detector.sv | 106 ++++++++++
 1 files changed

// File: rtl/button_press_detector.sv
// Multi-channel pushbutton conditioner: 2-FF synchroniser, debouncer, press/release/long-press
// pulses and a clearable sticky "pressed" flag per channel, plus a registered any_pressed summary.
module button_press_detector #(
    parameter int N_BUTTONS       = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_BUTTONS-1:0] btn_in,
    input  logic [N_BUTTONS-1:0] clear,
    output logic [N_BUTTONS-1:0] level,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse,
    output logic [N_BUTTONS-1:0] long_pulse,
    output logic [N_BUTTONS-1:0] pressed,
    output logic                 any_pressed
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        logic              sync1;
        logic              sync2;
        logic [DEB_W-1:0]  deb_cnt;
        logic [DEB_W-1:0]  deb_cnt_nxt;
        logic [HOLD_W-1:0] hold_cnt;
        logic [HOLD_W-1:0] hold_cnt_nxt;
        logic              flip;
        logic              level_q;
        logic              press_q;
        logic              release_q;
        logic              long_q;
        logic              pressed_q;

        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        always_comb begin
            flip        = 1'b0;
            deb_cnt_nxt = '0;
            if (sync2 != level_q) begin
                if (deb_cnt == DEB_LAST) begin
                    flip = 1'b1;
                end else begin
                    deb_cnt_nxt = deb_cnt + DEB_W'(1);
                end
            end
        end

        // Hold time saturates at the threshold so long_pulse fires once per press.
        always_comb begin
            hold_cnt_nxt = hold_cnt;
            if (!level_q) begin
                hold_cnt_nxt = '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end
        end

        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1     <= 1'b0;
                sync2     <= 1'b0;
                deb_cnt   <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                hold_cnt  <= '0;
                long_q    <= 1'b0;
                pressed_q <= 1'b0;
            end else begin
                sync1     <= btn_in[i];
                sync2     <= sync1;
                deb_cnt   <= deb_cnt_nxt;
                level_q   <= level_q ^ flip;
                press_q   <= flip & ~level_q;
                release_q <= flip & level_q;
                hold_cnt  <= hold_cnt_nxt;
                long_q    <= level_q & (hold_cnt == HOLD_LAST);
                // A press in the same cycle as a clear keeps the flag set.
                pressed_q <= press_q | (pressed_q & ~clear[i]);
            end
        end

        assign level[i]         = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_pulse[i]    = long_q;
        assign pressed[i]       = pressed_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_pressed <= 1'b0;
        end else begin
            any_pressed <= |pressed;
        end
    end

endmodule
